// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - fetch front-end bus bundle between CPU control/ROM side and the fetch unit
interface fetch_pc_unit_if;
    logic        Stall;
    logic [1:0]  PCSrc;
    logic [31:0] BranchOff;
    logic [25:0] JumpTarget;
    logic [31:0] RegTarget;
    logic [31:0] IData;
    logic [31:0] IAddr;
    logic        RW;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic [31:0] IR;
    logic        IRValid;
    logic        Halted;
    logic        Fault;
    logic [31:0] FetchCount;

    // Control/ROM side: drives redirect controls and the ROM word, observes fetch state
    modport master (
        output Stall, PCSrc, BranchOff, JumpTarget, RegTarget, IData,
        input  IAddr, RW, PC, PC4, IR, IRValid, Halted, Fault, FetchCount
    );

    // Fetch unit side
    modport slave (
        input  Stall, PCSrc, BranchOff, JumpTarget, RegTarget, IData,
        output IAddr, RW, PC, PC4, IR, IRValid, Halted, Fault, FetchCount
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC/IR fetch front end with BOOT/RUN/HALT FSM; FETCH_PERF_EN builds the fetch counter
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_BYTES   = 256,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic          CLK,
    input  logic          Reset,
    fetch_pc_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [32:0] LP_MEM_BYTES = 33'(MEM_BYTES);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_ir_valid;
    logic        r_fault;

    logic [31:0] w_pc4;
    logic [32:0] w_pc_end;
    logic [31:0] w_br_off;
    logic [31:0] w_pc_next;
    logic        w_fault_det;
    logic        w_halt_det;
    logic        w_capture;
    logic        w_fault_set;
    logic        w_pc_load;
    logic        w_rw;
    logic        w_halted;

    // Sequential successor and fetch-window checks; the end address is 33 bits so a PC near
    // the top of the address space cannot wrap back into range
    always_comb begin
        w_pc4       = r_pc + 32'd4;
        w_pc_end    = {1'b0, r_pc} + 33'd3;
        w_br_off    = bus.BranchOff << 2;
        w_fault_det = (r_pc[1:0] != 2'b00) || (w_pc_end >= LP_MEM_BYTES);
        w_halt_det  = (bus.IData[31:26] == HALT_OPCODE);
    end

    // Next-PC select; a misaligned RegTarget is taken as-is and faults on the following fetch
    always_comb begin
        w_pc_next = w_pc4;
        case (bus.PCSrc)
            2'b00:   w_pc_next = w_pc4;
            2'b01:   w_pc_next = w_pc4 + w_br_off;
            2'b10:   w_pc_next = {w_pc4[31:28], bus.JumpTarget, 2'b00};
            default: w_pc_next = bus.RegTarget;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and per-cycle fetch decisions; fault outranks halt, stall freezes RUN
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_fault_set  = 1'b0;
        w_pc_load    = 1'b0;
        w_rw         = 1'b1;
        w_halted     = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                w_rw = 1'b0;
                if (!bus.Stall) begin
                    if (w_fault_det) begin
                        w_fault_set  = 1'b1;
                        w_state_next = ST_HALT;
                    end else begin
                        w_capture = 1'b1;
                        if (w_halt_det) begin
                            w_state_next = ST_HALT;
                        end else begin
                            w_pc_load = 1'b1;
                        end
                    end
                end
            end
            ST_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    // PC, instruction register and sticky fault flag
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_pc       <= RESET_PC;
            r_ir       <= 32'h0000_0000;
            r_ir_valid <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            if (w_capture) begin
                r_ir       <= bus.IData;
                r_ir_valid <= 1'b1;
            end
            if (w_fault_set) begin
                r_fault    <= 1'b1;
                r_ir_valid <= 1'b0;
            end
            if (r_state == ST_HALT) begin
                r_ir_valid <= 1'b0;
            end
            if (w_pc_load) begin
                r_pc <= w_pc_next;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;

    // Saturating count of accepted instruction captures
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_fetch_count <= 32'h0000_0000;
        end else if (w_capture && (r_fetch_count != 32'hFFFF_FFFF)) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign bus.FetchCount = r_fetch_count;
`else
    assign bus.FetchCount = 32'h0000_0000;
`endif

    assign bus.IAddr   = r_pc;
    assign bus.PC      = r_pc;
    assign bus.PC4     = w_pc4;
    assign bus.RW      = w_rw;
    assign bus.IR      = r_ir;
    assign bus.IRValid = r_ir_valid;
    assign bus.Halted  = w_halted;
    assign bus.Fault   = r_fault;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

    logic CLK;
    logic Reset;
    logic [31:0] rom [0:63];
    int n_checks;
    int n_errors;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(
        .RESET_PC   (32'h0000_0000),
        .MEM_BYTES  (256),
        .HALT_OPCODE(6'b111111)
    ) u_dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus.slave)
    );

    assign bus.IData = rom[bus.IAddr[7:2]];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h want %08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef FETCH_PERF_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic load_rom();
        for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0000;
        rom[0]  = 32'h2001_0005;
        rom[1]  = 32'h2002_0003;
        rom[2]  = 32'h2003_0001;
        rom[3]  = 32'h2004_0002;
        rom[4]  = 32'h2005_0000;
        rom[63] = 32'h2006_AAAA;
    endtask

    // Reset for two edges, check reset values, release and step through BOOT
    task automatic do_reset(input string ph);
        Reset = 1'b0;
        bus.Stall = 1'b0;
        bus.PCSrc = 2'b00;
        tick();
        tick();
        check_val({ph, "_rst_pc"}, bus.PC, 32'h0);
        check_val({ph, "_rst_ir"}, bus.IR, 32'h0);
        check_val({ph, "_rst_irv"}, 32'(bus.IRValid), 32'h0);
        check_val({ph, "_rst_halt"}, 32'(bus.Halted), 32'h0);
        check_val({ph, "_rst_fault"}, 32'(bus.Fault), 32'h0);
        check_val({ph, "_rst_cnt"}, bus.FetchCount, 32'h0);
        Reset = 1'b1;
        check_val({ph, "_boot_rw"}, 32'(bus.RW), 32'h1);
        tick();
        check_val({ph, "_run_rw"}, 32'(bus.RW), 32'h0);
        check_val({ph, "_run_pc"}, bus.PC, 32'h0);
        check_val({ph, "_run_irv"}, 32'(bus.IRValid), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        Reset = 1'b0;
        bus.Stall = 1'b0;
        bus.PCSrc = 2'b00;
        bus.BranchOff = 32'h0;
        bus.JumpTarget = 26'h0;
        bus.RegTarget = 32'h0;
        load_rom();

        // Sequential fetch, stall, branch and jump
        do_reset("p1");
        check_val("p1_iaddr", bus.IAddr, 32'h0);
        tick();
        check_val("p1_pc4", bus.PC, 32'h4);
        check_val("p1_ir0", bus.IR, 32'h2001_0005);
        check_val("p1_irv0", 32'(bus.IRValid), 32'h1);
        check_val("p1_pc4o", bus.PC4, 32'h8);
        tick();
        check_val("p1_pc8", bus.PC, 32'h8);
        check_val("p1_ir1", bus.IR, 32'h2002_0003);
        check_val("p1_cnt2", bus.FetchCount, exp_cnt(2));
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("stall_pc", bus.PC, 32'h8);
            check_val("stall_ir", bus.IR, 32'h2002_0003);
            check_val("stall_irv", 32'(bus.IRValid), 32'h1);
            check_val("stall_rw", 32'(bus.RW), 32'h0);
            check_val("stall_cnt", bus.FetchCount, exp_cnt(2));
        end
        bus.Stall = 1'b0;
        tick();
        check_val("resume_pc", bus.PC, 32'h0C);
        check_val("resume_ir", bus.IR, 32'h2003_0001);
        check_val("resume_cnt", bus.FetchCount, exp_cnt(3));
        tick();
        check_val("p1_pc10", bus.PC, 32'h10);
        bus.PCSrc = 2'b01;
        bus.BranchOff = 32'hFFFF_FFFE;
        tick();
        check_val("branch_pc", bus.PC, 32'h0C);
        check_val("branch_ir", bus.IR, 32'h2005_0000);
        bus.PCSrc = 2'b10;
        bus.JumpTarget = 26'h000_0010;
        tick();
        check_val("jump_pc", bus.PC, 32'h40);
        check_val("jump_ir", bus.IR, 32'h2004_0002);
        check_val("jump_cnt", bus.FetchCount, exp_cnt(6));
        bus.PCSrc = 2'b00;

        // Halt opcode at 0x0C
        Reset = 1'b0;
        rom[3] = 32'hFC00_0000;
        do_reset("p2");
        tick();
        tick();
        tick();
        check_val("p2_pc_c", bus.PC, 32'h0C);
        tick();
        check_val("halt_ir", bus.IR, 32'hFC00_0000);
        check_val("halt_flag", 32'(bus.Halted), 32'h1);
        check_val("halt_pc", bus.PC, 32'h0C);
        check_val("halt_irv1", 32'(bus.IRValid), 32'h1);
        check_val("halt_cnt", bus.FetchCount, exp_cnt(4));
        bus.PCSrc = 2'b11;
        bus.RegTarget = 32'h0000_0080;
        bus.Stall = 1'b1;
        tick();
        check_val("halt_irv0", 32'(bus.IRValid), 32'h0);
        check_val("halt_rw", 32'(bus.RW), 32'h1);
        bus.Stall = 1'b0;
        tick();
        check_val("halt_pc_hold", bus.PC, 32'h0C);
        check_val("halt_ir_hold", bus.IR, 32'hFC00_0000);
        check_val("halt_stay", 32'(bus.Halted), 32'h1);
        check_val("halt_fault0", 32'(bus.Fault), 32'h0);

        // Register jump to the last valid word, then fault on 0x100
        Reset = 1'b0;
        load_rom();
        do_reset("p3");
        tick();
        bus.PCSrc = 2'b11;
        bus.RegTarget = 32'h0000_00FC;
        tick();
        check_val("rj_pc", bus.PC, 32'hFC);
        bus.PCSrc = 2'b00;
        tick();
        check_val("edge_ir", bus.IR, 32'h2006_AAAA);
        check_val("edge_pc", bus.PC, 32'h100);
        check_val("edge_fault", 32'(bus.Fault), 32'h0);
        tick();
        check_val("oor_fault", 32'(bus.Fault), 32'h1);
        check_val("oor_halt", 32'(bus.Halted), 32'h1);
        check_val("oor_irv", 32'(bus.IRValid), 32'h0);
        check_val("oor_ir", bus.IR, 32'h2006_AAAA);
        check_val("oor_pc", bus.PC, 32'h100);
        check_val("oor_cnt", bus.FetchCount, exp_cnt(3));

        // Reset out of faulted HALT
        Reset = 1'b0;
        tick();
        check_val("hrst_pc", bus.PC, 32'h0);
        check_val("hrst_fault", 32'(bus.Fault), 32'h0);
        check_val("hrst_halt", 32'(bus.Halted), 32'h0);
        check_val("hrst_rw", 32'(bus.RW), 32'h1);
        check_val("hrst_cnt", bus.FetchCount, 32'h0);

        // Misaligned register-jump target
        do_reset("p4");
        bus.PCSrc = 2'b11;
        bus.RegTarget = 32'h0000_0102;
        tick();
        check_val("mis_pc", bus.PC, 32'h102);
        check_val("mis_fault0", 32'(bus.Fault), 32'h0);
        bus.PCSrc = 2'b00;
        tick();
        check_val("mis_fault", 32'(bus.Fault), 32'h1);
        check_val("mis_halt", 32'(bus.Halted), 32'h1);
        check_val("mis_irv", 32'(bus.IRValid), 32'h0);
        check_val("mis_ir", bus.IR, 32'h2001_0005);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
